// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, field offsets and receive-parser state encoding.
// Used by both the ARP request transmitter and the ARP receive parser.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'h06;
    localparam logic [7:0]  ARP_PLEN       = 8'h04;
    localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

    // Byte offsets counted from the first byte after the SFD.
    localparam logic [5:0] OFS_DST   = 6'd0;
    localparam logic [5:0] OFS_SRC   = 6'd6;
    localparam logic [5:0] OFS_TYPE  = 6'd12;
    localparam logic [5:0] OFS_HTYPE = 6'd14;
    localparam logic [5:0] OFS_PTYPE = 6'd16;
    localparam logic [5:0] OFS_HLEN  = 6'd18;
    localparam logic [5:0] OFS_PLEN  = 6'd19;
    localparam logic [5:0] OFS_OPER  = 6'd20;
    localparam logic [5:0] OFS_SHA   = 6'd22;
    localparam logic [5:0] OFS_SPA   = 6'd28;
    localparam logic [5:0] OFS_THA   = 6'd32;
    localparam logic [5:0] OFS_TPA   = 6'd38;
    localparam logic [5:0] OFS_LAST  = 6'd41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HDR,
        ST_TRAIL,
        ST_DROP
    } rx_state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/arp_rx_parser.sv
// ARP receive parser: locks onto preamble/SFD, filters Ethernet II ARP frames
// addressed to this board and reports sender MAC/IP, opcode and statistics.
module arp_rx_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC    = 48'hACA62DBB53A1,
    parameter logic [31:0] LOCAL_IP     = 32'hC0A8000B,
    parameter int unsigned MIN_PREAMBLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [3:0]  rx_d1,
    input  logic [3:0]  rx_d2,
    output logic        arp_valid,
    output logic [15:0] arp_oper,
    output logic [47:0] sender_mac,
    output logic [31:0] sender_ip,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [2:0] MIN_PRE = 3'(MIN_PREAMBLE);

    rx_state_t   state, state_next;
    logic [5:0]  byte_idx, byte_idx_next;
    logic [2:0]  pre_cnt, pre_cnt_next;
    logic        bcast_ok, bcast_next, ucast_ok, ucast_next;
    logic [7:0]  rx_byte, exp_byte, ucast_byte;
    logic        chk_en, bcast_hit, ucast_hit, field_bad;
    logic        accept, drop;
    logic [15:0] oper_shadow;
    logic [47:0] sha_shadow;
    logic [31:0] spa_shadow;

    assign rx_byte = {rx_d2, rx_d1};

    // Expected value for each fixed header byte and the unicast MAC byte at the same index.
    always_comb begin
        chk_en     = 1'b0;
        exp_byte   = '0;
        ucast_byte = '0;
        case (byte_idx)
            6'd0:  ucast_byte = LOCAL_MAC[47:40];
            6'd1:  ucast_byte = LOCAL_MAC[39:32];
            6'd2:  ucast_byte = LOCAL_MAC[31:24];
            6'd3:  ucast_byte = LOCAL_MAC[23:16];
            6'd4:  ucast_byte = LOCAL_MAC[15:8];
            6'd5:  ucast_byte = LOCAL_MAC[7:0];
            6'd12: begin chk_en = 1'b1; exp_byte = ETH_TYPE_ARP[15:8];   end
            6'd13: begin chk_en = 1'b1; exp_byte = ETH_TYPE_ARP[7:0];    end
            6'd14: begin chk_en = 1'b1; exp_byte = ARP_HTYPE_ETH[15:8];  end
            6'd15: begin chk_en = 1'b1; exp_byte = ARP_HTYPE_ETH[7:0];   end
            6'd16: begin chk_en = 1'b1; exp_byte = ARP_PTYPE_IPV4[15:8]; end
            6'd17: begin chk_en = 1'b1; exp_byte = ARP_PTYPE_IPV4[7:0];  end
            6'd18: begin chk_en = 1'b1; exp_byte = ARP_HLEN;             end
            6'd19: begin chk_en = 1'b1; exp_byte = ARP_PLEN;             end
            6'd38: begin chk_en = 1'b1; exp_byte = LOCAL_IP[31:24];      end
            6'd39: begin chk_en = 1'b1; exp_byte = LOCAL_IP[23:16];      end
            6'd40: begin chk_en = 1'b1; exp_byte = LOCAL_IP[15:8];       end
            6'd41: begin chk_en = 1'b1; exp_byte = LOCAL_IP[7:0];        end
            default: ;
        endcase
    end

    assign bcast_hit = bcast_ok && (rx_byte == 8'hFF);
    assign ucast_hit = ucast_ok && (rx_byte == ucast_byte);
    assign field_bad = (byte_idx < OFS_SRC) ? !(bcast_hit || ucast_hit)
                                            : (chk_en && (rx_byte != exp_byte));

    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        pre_cnt_next  = pre_cnt;
        bcast_next    = bcast_ok;
        ucast_next    = ucast_ok;
        accept        = 1'b0;
        drop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_dv) begin
                    if (rx_byte == PREAMBLE_BYTE) begin
                        state_next   = ST_PREAMBLE;
                        pre_cnt_next = 3'd1;
                    end else begin
                        state_next = ST_TRAIL;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv) begin
                    state_next = ST_IDLE;
                end else if (rx_er) begin
                    state_next = ST_TRAIL;
                end else if (rx_byte == PREAMBLE_BYTE) begin
                    pre_cnt_next = (pre_cnt == 3'd7) ? 3'd7 : pre_cnt + 3'd1;
                end else if ((rx_byte == SFD_BYTE) && (pre_cnt >= MIN_PRE)) begin
                    state_next    = ST_HDR;
                    byte_idx_next = OFS_DST;
                    bcast_next    = 1'b1;
                    ucast_next    = 1'b1;
                end else begin
                    state_next = ST_TRAIL;
                end
            end
            ST_HDR: begin
                if (!rx_dv) begin
                    state_next = ST_IDLE;
                    drop       = 1'b1;
                end else if (rx_er || field_bad) begin
                    state_next = ST_DROP;
                    drop       = 1'b1;
                end else if (byte_idx == OFS_LAST) begin
                    state_next = ST_TRAIL;
                    accept     = 1'b1;
                end else begin
                    byte_idx_next = byte_idx + 6'd1;
                    bcast_next    = bcast_hit;
                    ucast_next    = ucast_hit;
                end
            end
            ST_TRAIL, ST_DROP: begin
                if (!rx_dv) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
            pre_cnt  <= '0;
            bcast_ok <= 1'b0;
            ucast_ok <= 1'b0;
        end else begin
            state    <= state_next;
            byte_idx <= byte_idx_next;
            pre_cnt  <= pre_cnt_next;
            bcast_ok <= bcast_next;
            ucast_ok <= ucast_next;
        end
    end

    // Shadows fill MSB-first; outputs only see them once the whole frame has passed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oper_shadow <= '0;
            sha_shadow  <= '0;
            spa_shadow  <= '0;
        end else if ((state == ST_HDR) && rx_dv && !rx_er) begin
            if ((byte_idx >= OFS_OPER) && (byte_idx < OFS_SHA)) begin
                oper_shadow <= {oper_shadow[7:0], rx_byte};
            end
            if ((byte_idx >= OFS_SHA) && (byte_idx < OFS_SPA)) begin
                sha_shadow <= {sha_shadow[39:0], rx_byte};
            end
            if ((byte_idx >= OFS_SPA) && (byte_idx < OFS_THA)) begin
                spa_shadow <= {spa_shadow[23:0], rx_byte};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arp_valid  <= 1'b0;
            arp_oper   <= '0;
            sender_mac <= '0;
            sender_ip  <= '0;
        end else begin
            arp_valid <= accept;
            if (accept) begin
                arp_oper   <= oper_shadow;
                sender_mac <= sha_shadow;
                sender_ip  <= spa_shadow;
            end
        end
    end

    sat_counter16 u_frame_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (accept),
        .count (frame_cnt)
    );

    sat_counter16 u_drop_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (drop),
        .count (drop_cnt)
    );

endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Receive-side counterpart of the ARP request transmitter.
- Consumes the PHY receive nibble stream: one byte per clk, split as two nibbles with low nibble first. Finds preamble and SFD, then parses the Ethernet II header and the ARP payload.
- Filters frames addressed to this board and reports the sender MAC/IP, the operation code, and accept/drop statistics.
- Sits between the PHY RX interface and the ARP cache/responder logic.

Parameters:
- LOCAL_MAC, 48'hACA62DBB53A1, board MAC; unicast destination accepted besides broadcast FF:FF:FF:FF:FF:FF.
- LOCAL_IP, 32'hC0A8000B (192.168.0.11), required target protocol address.
- MIN_PREAMBLE, 2, minimum count of 0x55 bytes before SFD (range 1..7).

Ports:
- clk  in  1  receive clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- rx_dv  in  1  receive data valid.
- rx_er  in  1  receive error.
- rx_d1  in  4  low nibble of current byte.
- rx_d2  in  4  high nibble of current byte; byte = {rx_d2, rx_d1}.
- arp_valid  out  1  one-cycle pulse when an accepted ARP frame completes.
- arp_oper  out  16  operation field (1 = request, 2 = reply).
- sender_mac  out  48  sender hardware address.
- sender_ip  out  32  sender protocol address.
- frame_cnt  out  16  accepted frames, saturating.
- drop_cnt  out  16  dropped frames, saturating.

Behaviour:
- Reset (rst=0, async): state=IDLE; byte_idx=0; pre_cnt=0. arp_valid, arp_oper, sender_mac, sender_ip, frame_cnt and drop_cnt all 0. A reset mid-frame abandons the frame with no counter update.
- Byte sampling: a byte is sampled only when rx_dv=1. Byte index 0 is the first byte after SFD. Fields are big-endian, MSB byte first.
- States: IDLE, PREAMBLE, HDR, TRAIL, DROP.
- IDLE:
  - rx_dv=1 with byte 0x55 -> PREAMBLE, pre_cnt=1.
  - Any other byte -> TRAIL.
- PREAMBLE:
  - 0x55 -> pre_cnt++ (saturates at 7).
  - 0xD5 with pre_cnt >= MIN_PREAMBLE -> HDR, byte_idx=0.
  - Any other byte, rx_er=1, or rx_dv=0 -> TRAIL (or IDLE if rx_dv=0). No counter change.
- HDR: each byte is checked or captured by byte_idx.
  - 0-5: destination MAC; must equal all-FF or LOCAL_MAC, evaluated as a running per-byte match for both.
  - 6-11: source MAC, ignored.
  - 12-13: must be 08 06.
  - 14-15: must be 00 01.
  - 16-17: must be 08 00.
  - 18: must be 06.
  - 19: must be 04.
  - 20-21: captured to oper_shadow.
  - 22-27: captured to sha_shadow.
  - 28-31: captured to spa_shadow.
  - 32-37: target MAC, ignored.
  - 38-41: must equal LOCAL_IP.
- Mismatch: first mismatching byte -> DROP, drop_cnt++. Both destination options failing counts as a mismatch at that byte.
- Byte 41 accepted:
  - Next cycle arp_valid=1 for exactly one clk.
  - arp_oper, sender_mac and sender_ip are loaded from the shadows on that same edge and held until the next accept.
  - frame_cnt++.
  - State -> TRAIL.
- Latency: arp_valid rises 1 clk after byte 41 is sampled.
- rx_er=1 in HDR -> DROP, drop_cnt++.
- rx_dv=0 in HDR before byte 41 (runt) -> IDLE, drop_cnt++.
- TRAIL and DROP: ignore bytes (padding and FCS included) until rx_dv=0, then IDLE. FCS is not checked in this block.
- A frame needs rx_dv low for at least 1 clk before the next preamble is recognised.
- Counters saturate at 16'hFFFF; no wrap.
- Output registers change only on accept or reset; a dropped frame never disturbs the previous result.
- byte_idx is 6 bits; it never exceeds 41 in HDR.

Decomposition:
- Shared package eth_pkg:
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, ETH_TYPE_ARP=16'h0806, ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'h06, ARP_PLEN=8'h04, ARP_OP_REQ=16'h0001, ARP_OP_REPLY=16'h0002;
  - ARP field byte offsets;
  - state encoding.
- The transmitter is to be moved onto the same package.
- One natural sub-module: sat_counter16 (increment enable, saturating), instantiated twice.

Test Plan:
- 7×0x55, 0xD5, then an ARP reply: dst ACA62DBB53A1, oper 0002, sha 001122334455, spa C0A80D45, tpa C0A8000B, plus 18 pad bytes and 4 FCS bytes -> exactly one arp_valid pulse 1 clk after byte 41; sender_mac=001122334455, sender_ip=C0A80D45, arp_oper=0002, frame_cnt=1, drop_cnt=0.
- Same frame with broadcast destination and oper 0001 -> accepted, arp_oper=0001, frame_cnt increments.
- Ethertype 0800 at bytes 12-13 -> no arp_valid, drop_cnt+1, previous sender_mac/ip unchanged.
- tpa C0A8000C -> drop at byte 41, drop_cnt+1. Then a back-to-back valid frame after 1 idle clk -> accepted.
- rx_er pulsed at byte 25, and separately rx_dv dropped at byte 30 -> each gives drop_cnt+1, no arp_valid. Single 0x55 before SFD with MIN_PREAMBLE=2 -> ignored with no counter change.
- rst asserted low mid-HDR, asynchronously between edges -> all outputs 0 immediately. The next full frame is accepted normally. Preload drop_cnt to FFFF via 65535 bad frames (or force) -> it stays FFFF.
